// File: rtl/filter2d_ctrl.sv
// Frame sequencer for the 3x3 filter2d datapath: coefficient download, start, raster write-back.
// Optional sticky interrupt (irq/irq_clr) is built when FILTER2D_CTRL_IRQ_EN is defined.
module filter2d_ctrl #(
  parameter int NPIX    = 65536,
  parameter int NTAP    = 9,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_idx,
  input  logic signed [7:0] cfg_data,
  input  logic              go,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              h_write,
  output logic [3:0]        h_idx,
  output logic signed [7:0] h_data,
  output logic              op_start,
  input  logic              op_strb,
  input  logic [7:0]        op_data,
  output logic              wr_en,
  output logic [15:0]       wr_addr,
  output logic [7:0]        wr_data
`ifdef FILTER2D_CTRL_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int CNT_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [3:0]       LAST_TAP = 4'(NTAP - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_KICK  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // Power-up kernel: 3x3 Gaussian-like smoothing weights.
  function automatic logic signed [COEF_W-1:0] default_coef(input int i);
    case (i)
      4:          return 8'sh20;
      1, 3, 5, 7: return 8'sh10;
      default:    return 8'sh08;
    endcase
  endfunction

  logic [2:0]               state, nxt_state;
  logic [3:0]               load_idx;
  logic [CNT_W-1:0]         pix_cnt;
  logic [WD_W-1:0]          wdog;
  logic signed [COEF_W-1:0] shadow [NTAP];
  logic                     vld_p1;
  logic [15:0]              addr_p1;
  logic [DATA_W-1:0]        data_p1;
  logic                     in_flow, strb_hit, last_hit, wd_expire, go_ok;

  assign in_flow   = (state == S_RUN) || (state == S_DRAIN);
  assign strb_hit  = in_flow && op_strb;
  assign last_hit  = strb_hit && (pix_cnt == LAST_PIX);
  assign wd_expire = in_flow && !op_strb && (wdog == WD_LIMIT);
  assign go_ok     = (state == S_IDLE) && go && !abort;

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:  if (go_ok) nxt_state = S_LOAD;
      S_LOAD: begin
        if (abort)                     nxt_state = S_IDLE;
        else if (load_idx == LAST_TAP) nxt_state = S_KICK;
      end
      S_KICK:  nxt_state = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        // An abort on the final strobe still suppresses that write and the done pulse.
        if (last_hit)       nxt_state = abort ? S_IDLE : S_DONE;
        else if (wd_expire) nxt_state = S_ERR;
        else if (abort)     nxt_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_hit)       nxt_state = S_IDLE;
        else if (wd_expire) nxt_state = S_ERR;
      end
      S_DONE:  nxt_state = S_IDLE;
      S_ERR:   nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      load_idx    <= '0;
      pix_cnt     <= '0;
      wdog        <= '0;
      err_timeout <= 1'b0;
      vld_p1      <= 1'b0;
      addr_p1     <= '0;
      data_p1     <= '0;
    end else begin
      state    <= nxt_state;
      load_idx <= (state == S_LOAD && nxt_state == S_LOAD) ? load_idx + 4'd1 : 4'd0;
      if (state == S_KICK)
        pix_cnt <= '0;
      else if (strb_hit)
        pix_cnt <= pix_cnt + 1'b1;
      if (!in_flow || op_strb)
        wdog <= '0;
      else
        wdog <= wdog + 1'b1;
      if (go_ok)
        err_timeout <= 1'b0;
      else if (nxt_state == S_ERR)
        err_timeout <= 1'b1;
      // Stage p1: strobe captured, write presented one cycle later.
      vld_p1 <= strb_hit && (state == S_RUN) && !abort;
      if (strb_hit) begin
        addr_p1 <= 16'(pix_cnt);
        data_p1 <= op_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAP; i++) shadow[i] <= default_coef(i);
    end else if (state == S_IDLE && cfg_we && int'(cfg_idx) < NTAP) begin
      shadow[cfg_idx] <= cfg_data;
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign op_start = (state == S_KICK);
  assign h_write  = (state == S_LOAD);
  assign h_idx    = load_idx;
  assign h_data   = h_write ? shadow[load_idx] : '0;
  assign wr_en    = vld_p1;
  assign wr_addr  = addr_p1;
  assign wr_data  = data_p1;

`ifdef FILTER2D_CTRL_IRQ_EN
  logic irq_set;
  assign irq_set = (nxt_state == S_DONE) || (nxt_state == S_ERR && !err_timeout);

  always_ff @(posedge clk) begin
    if (reset)        irq <= 1'b0;
    else if (irq_set) irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_filter2d_ctrl.sv
// Bench for filter2d_ctrl with a small datapath model (NPIX=16, strobe every 12 cycles).
module tb_filter2d_ctrl;
  localparam int NPIX    = 16;
  localparam int NTAP    = 9;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 12;

  logic        clk = 1'b0;
  logic        reset, cfg_we, go, abort, op_strb;
  logic [3:0]  cfg_idx;
  logic [7:0]  cfg_data, op_data;
  logic        busy, done, err_timeout, h_write, op_start, wr_en;
  logic [3:0]  h_idx;
  logic [7:0]  h_data, wr_data;
  logic [15:0] wr_addr;
`ifdef FILTER2D_CTRL_IRQ_EN
  logic        irq, irq_clr;
`endif

  filter2d_ctrl #(.NPIX(NPIX), .NTAP(NTAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .go(go), .abort(abort), .busy(busy), .done(done), .err_timeout(err_timeout),
    .h_write(h_write), .h_idx(h_idx), .h_data(h_data), .op_start(op_start),
    .op_strb(op_strb), .op_data(op_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef FILTER2D_CTRL_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t sb[$];
  wr_t sb_e;

  logic [7:0] dflt [NTAP] = '{8'h08, 8'h10, 8'h08, 8'h10, 8'h20, 8'h10, 8'h08, 8'h10, 8'h08};
  logic [7:0] exp_coef [NTAP];

  // Datapath model: armed by op_start, one strobe every GAP cycles up to m_limit.
  int   m_limit = NPIX;
  bit   m_act = 0;
  int   m_gap = 0;
  int   m_n = 0;
  bit   wr_expected = 1;
  int   last_strb_cyc = 0;
  int   clr_req = 0;
  int   clr_ack = 0;
  bit   clr_at_last = 0;

  initial begin
    op_strb = 1'b0;
    op_data = 8'h00;
`ifdef FILTER2D_CTRL_IRQ_EN
    irq_clr = 1'b0;
`endif
    forever begin
      @(negedge clk);
      op_strb = 1'b0;
`ifdef FILTER2D_CTRL_IRQ_EN
      irq_clr = (clr_req != clr_ack);
      clr_ack = clr_req;
`endif
      if (reset) begin
        m_act = 0;
      end else if (op_start) begin
        m_act = 1; m_gap = 0; m_n = 0;
      end else if (m_act) begin
        m_gap++;
        if (m_gap == GAP) begin
          m_gap   = 0;
          op_strb = 1'b1;
          op_data = 8'h03 + 8'(m_n * 29);
          if (wr_expected) sb.push_back('{addr: 16'(m_n), data: op_data});
`ifdef FILTER2D_CTRL_IRQ_EN
          if (clr_at_last && m_n == NPIX - 1) irq_clr = 1'b1;
`endif
          last_strb_cyc = cyc;
          m_n++;
          if (m_n >= m_limit) m_act = 0;
        end
      end
    end
  end

  int n_wr = 0;
  int n_done = 0;
  int done_cyc = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (wr_en) begin
        n_wr++;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got write addr=%0h data=%0h, expected no write (cycle %0d)",
                   wr_addr, wr_data, cyc);
        end else begin
          sb_e = sb.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(sb_e.addr));
          check("wr_data", 32'(wr_data), 32'(sb_e.data));
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("done_with_last_wr", 32'({wr_en, wr_addr}), 32'({1'b1, 16'(NPIX - 1)}));
`ifdef FILTER2D_CTRL_IRQ_EN
        check("irq_with_done", 32'(irq), 32'd1);
`endif
      end
    end
  end

  task automatic wait_idle(input int budget, input string name, output int at);
    at = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy) begin
        at = cyc;
        break;
      end
      step();
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  task automatic wait_wr(input int target, input int budget, input string name);
    bit hit;
    hit = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (n_wr >= target) begin
        hit = 1;
        break;
      end
      step();
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL %s: writes=%0d expected %0d within %0d cycles", name, n_wr, target, budget);
    end
  endtask

  // Accept go, verify the 9-tap download and the op_start cycle; ends on the op_start negedge.
  task automatic start_and_load();
    go = 1'b1;
    step();
    go = 1'b0;
    cfg_we = 1'b0;
    for (int k = 0; k < NTAP; k++) begin
      @(negedge clk);
      check($sformatf("load_hw[%0d]", k), 32'(h_write), 32'd1);
      check($sformatf("load_idx[%0d]", k), 32'(h_idx), 32'(k));
      check($sformatf("load_data[%0d]", k), 32'(h_data), 32'(exp_coef[k]));
      step();
    end
    @(negedge clk);
    check("load_op_start", 32'({op_start, h_write}), 32'b10);
  endtask

  typedef struct packed {
    logic       go;
    logic       busy;
    logic       hw;
    logic [3:0] idx;
    logic [7:0] hd;
    logic       st;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int at, seen, err_at;
    tbl[0]  = '{go: 1'b1, busy: 1'b0, hw: 1'b0, idx: 4'd0, hd: 8'h00, st: 1'b0};
    tbl[1]  = '{go: 1'b0, busy: 1'b1, hw: 1'b1, idx: 4'd0, hd: 8'h08, st: 1'b0};
    tbl[2]  = '{go: 1'b0, busy: 1'b1, hw: 1'b1, idx: 4'd1, hd: 8'h10, st: 1'b0};
    tbl[3]  = '{go: 1'b0, busy: 1'b1, hw: 1'b1, idx: 4'd2, hd: 8'h08, st: 1'b0};
    tbl[4]  = '{go: 1'b0, busy: 1'b1, hw: 1'b1, idx: 4'd3, hd: 8'h10, st: 1'b0};
    tbl[5]  = '{go: 1'b0, busy: 1'b1, hw: 1'b1, idx: 4'd4, hd: 8'h20, st: 1'b0};
    tbl[6]  = '{go: 1'b0, busy: 1'b1, hw: 1'b1, idx: 4'd5, hd: 8'h10, st: 1'b0};
    tbl[7]  = '{go: 1'b0, busy: 1'b1, hw: 1'b1, idx: 4'd6, hd: 8'h08, st: 1'b0};
    tbl[8]  = '{go: 1'b0, busy: 1'b1, hw: 1'b1, idx: 4'd7, hd: 8'h10, st: 1'b0};
    tbl[9]  = '{go: 1'b0, busy: 1'b1, hw: 1'b1, idx: 4'd8, hd: 8'h08, st: 1'b0};
    tbl[10] = '{go: 1'b0, busy: 1'b1, hw: 1'b0, idx: 4'd0, hd: 8'h00, st: 1'b1};
    tbl[11] = '{go: 1'b0, busy: 1'b1, hw: 1'b0, idx: 4'd0, hd: 8'h00, st: 1'b0};
    for (int i = 0; i < NTAP; i++) exp_coef[i] = dflt[i];

    reset = 1'b1; cfg_we = 1'b0; cfg_idx = 4'd0; cfg_data = 8'h00; go = 1'b0; abort = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("reset_ctrl", 32'({busy, done, err_timeout, h_write, h_idx, h_data, op_start, wr_en}), 32'd0);
    check("reset_wr", 32'({wr_addr, wr_data}), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Frame 1: default coefficients, latency table, full frame.
    for (int i = 0; i < 12; i++) begin
      go = tbl[i].go;
      @(negedge clk);
      check($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("t1_hw[%0d]", i), 32'(h_write), 32'(tbl[i].hw));
      check($sformatf("t1_idx[%0d]", i), 32'(h_idx), 32'(tbl[i].idx));
      check($sformatf("t1_hd[%0d]", i), 32'(h_data), 32'(tbl[i].hd));
      check($sformatf("t1_start[%0d]", i), 32'(op_start), 32'(tbl[i].st));
      step();
    end
    wait_idle(400, "t1_idle", at);
    check("t1_busy_drop", 32'(at), 32'(done_cyc + 1));
    check("t1_writes", 32'(n_wr), 32'(NPIX));
    check("t1_done", 32'(n_done), 32'd1);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    step();

    // Frame 2: shadow writes in IDLE, out-of-range index, write coincident with go, write during RUN.
    cfg_we = 1'b1; cfg_idx = 4'd4; cfg_data = 8'hF0;
    step();
    cfg_idx = 4'd9; cfg_data = 8'h55;
    step();
    exp_coef[4] = 8'hF0;
    cfg_idx = 4'd2; cfg_data = 8'hC3;
    exp_coef[2] = 8'hC3;
    start_and_load();
    step();
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_data = 8'h7F;
    step();
    cfg_we = 1'b0;
    wait_idle(400, "t2_idle", at);
    check("t2_writes", 32'(n_wr), 32'(2 * NPIX));
    check("t2_done", 32'(n_done), 32'd2);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);
    step();

    // Frame 3: abort after 5 writes, drain to the last strobe, go during DRAIN ignored.
    start_and_load();
    step();
    wait_wr(2 * NPIX + 5, 200, "t3_five_writes");
    step();
    abort = 1'b1;
    wr_expected = 0;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("t3_drain_busy", 32'(busy), 32'd1);
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    @(negedge clk);
    check("t3_go_in_drain", 32'({h_write, busy}), 32'b01);
    step();
    wait_idle(300, "t3_idle", at);
    check("t3_idle_after_last_strb", 32'(at), 32'(last_strb_cyc + 1));
    check("t3_strobes", 32'(m_n), 32'(NPIX));
    check("t3_writes", 32'(n_wr), 32'(2 * NPIX + 5));
    check("t3_no_done", 32'(n_done), 32'd2);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    step();
    wr_expected = 1;

    // Frame 4: datapath stalls after 3 strobes -> watchdog error.
    m_limit = 3;
    start_and_load();
    step();
    err_at = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (err_timeout) begin
        err_at = cyc;
        break;
      end
      step();
    end
    if (err_at < 0) begin
      total++; bad++;
      $display("FAIL t4_err_wait: err_timeout still 0 after 300 cycles, expected 1");
    end
    check("t4_err_cycle", 32'(err_at), 32'(last_strb_cyc + TIMEOUT + 1));
    check("t4_err_busy", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    check("t4_after_err", 32'({busy, err_timeout}), 32'b01);
    check("t4_writes", 32'(n_wr), 32'(2 * NPIX + 8));
    check("t4_no_done", 32'(n_done), 32'd2);
    step();
    m_limit = NPIX;

    // go+abort together is dropped; then go clears the error; abort at load index 3.
    go = 1'b1; abort = 1'b1;
    step();
    go = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("t5_go_abort", 32'({busy, h_write, err_timeout}), 32'b001);
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    @(negedge clk);
    check("t5_err_cleared", 32'({err_timeout, h_write}), 32'b01);
    for (int k = 1; k <= 3; k++) step();
    @(negedge clk);
    check("t5_load_idx3", 32'(h_idx), 32'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("t5_abort_load", 32'({busy, h_write}), 32'b00);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      @(negedge clk);
      if (op_start || busy) seen++;
    end
    check("t5_no_start", 32'(seen), 32'd0);
    step();

`ifdef FILTER2D_CTRL_IRQ_EN
    // irq set by earlier done/error; clear it, then check set/hold/clear and set-wins.
    clr_req++;
    step(); step();
    @(negedge clk);
    check("irq_cleared0", 32'(irq), 32'd0);
    step();
    start_and_load();
    step();
    wait_idle(400, "irq_f1_idle", at);
    check("irq_held", 32'(irq), 32'd1);
    step();
    clr_req++;
    step(); step();
    @(negedge clk);
    check("irq_cleared1", 32'(irq), 32'd0);
    step();
    clr_at_last = 1;
    start_and_load();
    step();
    wait_idle(400, "irq_f2_idle", at);
    check("irq_set_wins", 32'(irq), 32'd1);
    clr_at_last = 0;
    step();
`endif

    // Reset in the middle of a coefficient load.
    go = 1'b1;
    step();
    go = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("midreset_ctrl", 32'({busy, done, err_timeout, h_write, h_idx, h_data, op_start, wr_en}), 32'd0);
    check("midreset_wr", 32'({wr_addr, wr_data}), 32'd0);
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
